count_decoder: RTL and testbench

//  Decodes counter values back to plain binary: a Gray-coded count and a packed-BCD

---
 rtl/counters_pkg.sv | 40 ++++
 rtl/gray_to_bin.sv | 20 ++
 rtl/count_decoder.sv | 145 ++++++++++++++
 tb/tb_count_decoder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/counters_pkg.sv
// -----------------------------------------------------------------------------
// counters_pkg
//   Shared definitions for blocks that consume Gray and BCD counter values.
//   - state_t    : conversion FSM states (IDLE, CONVERT, DONE)
//   - BCD_RADIX  : decimal radix used by the BCD accumulator
//   - GRAY_MAX_W : widest Gray word gray2bin() can decode
//   - gray2bin() : prefix-XOR Gray-to-binary decode over the low 'width' bits
// -----------------------------------------------------------------------------
package counters_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int BCD_RADIX  = 10;
    localparam int GRAY_MAX_W = 64;

    // b[MSB] = g[MSB], b[i] = b[i+1] ^ g[i]. A running XOR from the top bit
    // down gives exactly that. Bits at or above 'width' are returned as 0, so
    // callers pass a zero-extended word and cast the result to their width.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(
        input logic [GRAY_MAX_W-1:0] g,
        input int                    width
    );
        logic [GRAY_MAX_W-1:0] b;
        logic                  run;
        b   = '0;
        run = 1'b0;
        for (int i = GRAY_MAX_W - 1; i >= 0; i--) begin
            if (i < width) begin
                run  = run ^ g[i];
                b[i] = run;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// -----------------------------------------------------------------------------
// gray_to_bin
//   Combinational Gray-to-binary decoder (prefix XOR), reusable by any Gray
//   consumer. WIDTH must not exceed counters_pkg::GRAY_MAX_W.
//   Ports:
//     i_gray  in   WIDTH  Gray-coded word
//     o_bin   out  WIDTH  binary equivalent
// -----------------------------------------------------------------------------
module gray_to_bin
    import counters_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    assign o_bin = WIDTH'(gray2bin(GRAY_MAX_W'(i_gray), WIDTH));

endmodule

// File: rtl/count_decoder.sv
// -----------------------------------------------------------------------------
// count_decoder
//   Captures a Gray-coded count and a packed-BCD count together and returns
//   both as binary. The Gray word is decoded at acceptance and registered;
//   the BCD word is folded into an accumulator one digit per cycle, most
//   significant digit first (acc = acc*10 + digit).
//   Ports:
//     clk            in   1              rising-edge clock
//     clr_n          in   1              asynchronous active-low reset
//     in_valid       in   1              gray_in/bcd_in hold a value to decode
//     in_ready       out  1              high only in IDLE
//     gray_in        in   COUNT_SIZE     Gray-coded count
//     bcd_in         in   4*BCD_DIGITS   packed BCD, digit 0 in bits [3:0]
//     out_valid      out  1              result outputs are valid (DONE)
//     out_ready      in   1              consumer accepts the result
//     bin_from_gray  out  COUNT_SIZE     binary of the captured gray_in
//     bin_from_bcd   out  BIN_WIDTH      binary of the captured bcd_in
//     bcd_err        out  1              a captured digit was > 9
// -----------------------------------------------------------------------------
module count_decoder
    import counters_pkg::*;
#(
    parameter int COUNT_SIZE = 8,
    parameter int BCD_DIGITS = 4,
    parameter int BIN_WIDTH  = 14
) (
    input  logic                    clk,
    input  logic                    clr_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [COUNT_SIZE-1:0]   gray_in,
    input  logic [4*BCD_DIGITS-1:0] bcd_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [COUNT_SIZE-1:0]   bin_from_gray,
    output logic [BIN_WIDTH-1:0]    bin_from_bcd,
    output logic                    bcd_err
);

    localparam int              IDX_W     = (BCD_DIGITS > 1) ? $clog2(BCD_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BCD_DIGITS - 1);
    localparam logic [3:0]      MAX_DIGIT = 4'(BCD_RADIX - 1);

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    w_accept;
    logic                    w_step;
    logic                    w_last;
    logic [3:0]              w_digit;
    logic [COUNT_SIZE-1:0]   w_gray_bin;

    logic [4*BCD_DIGITS-1:0] r_bcd;
    logic [IDX_W-1:0]        r_idx;
    logic [BIN_WIDTH-1:0]    r_acc;
    logic [COUNT_SIZE-1:0]   r_bin_from_gray;
    logic                    r_bcd_err;

    gray_to_bin #(
        .WIDTH (COUNT_SIZE)
    ) u_gray_to_bin (
        .i_gray (gray_in),
        .o_bin  (w_gray_bin)
    );

    assign w_digit = r_bcd[4*int'(r_idx) +: 4];
    assign w_last  = (r_idx == '0);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // in_ready and out_valid are decoded from the state, so in_ready reads 1
    // throughout reset and out_valid drops on the edge that leaves DONE.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = CONVERT;
                end
            end
            CONVERT: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: the captured BCD word is reset along with everything else; it is a
    // handful of flops, not a memory, and clearing it keeps post-reset state
    // fully defined at no real cost.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_bcd           <= '0;
            r_idx           <= '0;
            r_acc           <= '0;
            r_bin_from_gray <= '0;
            r_bcd_err       <= 1'b0;
        end else if (w_accept) begin
            r_bcd           <= bcd_in;
            r_bin_from_gray <= w_gray_bin;
            r_acc           <= '0;
            r_bcd_err       <= 1'b0;
            r_idx           <= LAST_IDX;
        end else if (w_step) begin
            // acc*10 as two shifts and an add; wraps mod 2**BIN_WIDTH, which
            // only happens for illegal digits.
            r_acc <= (r_acc << 3) + (r_acc << 1) + BIN_WIDTH'(w_digit);
            if (w_digit > MAX_DIGIT) begin
                r_bcd_err <= 1'b1;
            end
            if (!w_last) begin
                r_idx <= r_idx - IDX_W'(1);
            end
        end
    end

    assign bin_from_gray = r_bin_from_gray;
    assign bin_from_bcd  = r_acc;
    assign bcd_err       = r_bcd_err;

endmodule

// File: tb/tb_count_decoder.sv
module tb_count_decoder;

    localparam int COUNT_SIZE = 8;
    localparam int BCD_DIGITS = 4;
    localparam int BIN_WIDTH  = 14;
    localparam int LATENCY    = BCD_DIGITS + 1;

    logic                    clk;
    logic                    clr_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [COUNT_SIZE-1:0]   gray_in;
    logic [4*BCD_DIGITS-1:0] bcd_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [COUNT_SIZE-1:0]   bin_from_gray;
    logic [BIN_WIDTH-1:0]    bin_from_bcd;
    logic                    bcd_err;

    count_decoder #(
        .COUNT_SIZE (COUNT_SIZE),
        .BCD_DIGITS (BCD_DIGITS),
        .BIN_WIDTH  (BIN_WIDTH)
    ) dut (
        .clk           (clk),
        .clr_n         (clr_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .gray_in       (gray_in),
        .bcd_in        (bcd_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .bin_from_gray (bin_from_gray),
        .bin_from_bcd  (bin_from_bcd),
        .bcd_err       (bcd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: the binary value whose Gray code (v ^ v>>1) equals g.
    function automatic int ref_gray(input logic [7:0] g);
        for (int v = 0; v < 256; v++) begin
            if (8'(v ^ (v >> 1)) == g) return v;
        end
        return -1;
    endfunction

    // Reference: positional decimal value of the digits, mod 2**BIN_WIDTH.
    function automatic int ref_bcd(input logic [15:0] b);
        int s;
        int p;
        s = 0;
        p = 1;
        for (int k = 0; k < BCD_DIGITS; k++) begin
            s = s + int'(b[4*k +: 4]) * p;
            p = p * 10;
        end
        return s % (1 << BIN_WIDTH);
    endfunction

    function automatic bit ref_err(input logic [15:0] b);
        for (int k = 0; k < BCD_DIGITS; k++) begin
            if (b[4*k +: 4] > 4'd9) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic drive_junk();
        in_valid = 1'($urandom_range(0, 1));
        gray_in  = 8'($urandom);
        bcd_in   = 16'($urandom);
    endtask

    // One full transaction: accept, measure latency, hold in DONE for 'hold'
    // cycles with out_ready low, then release and confirm return to IDLE.
    task automatic run_txn(input string tag, input logic [7:0] g, input logic [15:0] b,
                           input int eg, input int eb, input bit ee,
                           input int hold, input bit junk);
        int waited;
        int lat;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, " in_ready_before"}, in_ready, 1);
        in_valid  = 1'b1;
        gray_in   = g;
        bcd_in    = b;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            if (junk) drive_junk();
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, LATENCY);
        check({tag, " gray"}, bin_from_gray, eg);
        check({tag, " bcd"}, bin_from_bcd, eb);
        check({tag, " err"}, bcd_err, ee);
        for (int i = 0; i < hold; i++) begin
            if (junk) drive_junk();
            @(posedge clk); #1;
            check({tag, " hold_valid"}, out_valid, 1);
            check({tag, " hold_in_ready"}, in_ready, 0);
            check({tag, " hold_gray"}, bin_from_gray, eg);
            check({tag, " hold_bcd"}, bin_from_bcd, eb);
            check({tag, " hold_err"}, bcd_err, ee);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, " valid_drop"}, out_valid, 0);
        check({tag, " in_ready_after"}, in_ready, 1);
        check({tag, " gray_kept"}, bin_from_gray, eg);
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  gray;
        logic [15:0] bcd;
        int          exp_gray;
        int          exp_bcd;
        bit          exp_err;
        int          hold;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int seen;
        logic [7:0]  rg;
        logic [15:0] rb;

        vecs[0] = '{8'hC0, 16'h0128, 128,  128, 1'b0, 0};
        vecs[1] = '{8'h00, 16'h9999,   0, 9999, 1'b0, 2};
        vecs[2] = '{8'hFF, 16'h0000, 170,    0, 1'b0, 0};
        vecs[3] = '{8'h01, 16'h00A5,   1,  105, 1'b1, 10};
        vecs[4] = '{8'h80, 16'hFFFF, 255,  281, 1'b1, 3};
        vecs[5] = '{8'h55, 16'h0999, 102,  999, 1'b0, 1};

        clr_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        gray_in   = '0;
        bcd_in    = '0;
        #3;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset gray", bin_from_gray, 0);
        check("reset bcd", bin_from_bcd, 0);
        check("reset err", bcd_err, 0);
        // Inputs are ignored while in reset.
        in_valid = 1'b1;
        gray_in  = 8'hAA;
        bcd_in   = 16'h1234;
        repeat (2) @(posedge clk);
        #1;
        check("reset ignores input", bin_from_gray, 0);
        @(negedge clk);
        in_valid = 1'b0;
        clr_n    = 1'b1;

        foreach (vecs[i]) begin
            run_txn($sformatf("vec%0d", i), vecs[i].gray, vecs[i].bcd,
                    vecs[i].exp_gray, vecs[i].exp_bcd, vecs[i].exp_err,
                    vecs[i].hold, 1'b0);
        end

        // Reset two cycles after acceptance aborts the conversion.
        @(negedge clk);
        in_valid = 1'b1;
        gray_in  = 8'h80;
        bcd_in   = 16'h0128;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("abort captured gray", bin_from_gray, 255);
        repeat (2) @(posedge clk);
        #1;
        clr_n = 1'b0;
        #1;
        check("abort out_valid", out_valid, 0);
        check("abort gray", bin_from_gray, 0);
        check("abort bcd", bin_from_bcd, 0);
        check("abort err", bcd_err, 0);
        check("abort in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr_n     = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abort no stale result", seen, 0);
        check("abort in_ready after", in_ready, 1);
        out_ready = 1'b0;

        // Sweep every 8-bit value through both decoders.
        for (int i = 0; i < 256; i++) begin
            run_txn("sweep", 8'(i ^ (i >> 1)),
                    {4'd0, 4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)},
                    i, i, 1'b0, 0, 1'b0);
        end

        // Random transactions with junk on the inputs while busy.
        for (int n = 0; n < 150; n++) begin
            rg = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                rb = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                      4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            end else begin
                rb = 16'($urandom);
            end
            run_txn("rand", rg, rb, ref_gray(rg), ref_bcd(rb), ref_err(rb),
                    $urandom_range(0, 3), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
